// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: active-low GFEDCBA glyph patterns and capture FSM encoding.
// Used by the display decoder and by seven_seg_capture / seven_seg_encoder.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK   = 7'b1111111;
   localparam seg_t SEG_GLYPH_0 = 7'b1000000;
   localparam seg_t SEG_GLYPH_1 = 7'b1111001;
   localparam seg_t SEG_GLYPH_2 = 7'b0100100;
   localparam seg_t SEG_GLYPH_3 = 7'b0110000;
   localparam seg_t SEG_GLYPH_4 = 7'b0011001;
   localparam seg_t SEG_GLYPH_5 = 7'b0010010;
   localparam seg_t SEG_GLYPH_6 = 7'b0000010;
   localparam seg_t SEG_GLYPH_7 = 7'b1111000;
   localparam seg_t SEG_GLYPH_8 = 7'b0000000;
   localparam seg_t SEG_GLYPH_9 = 7'b0010000;
   localparam seg_t SEG_GLYPH_A = 7'b0001000;
   localparam seg_t SEG_GLYPH_B = 7'b0000011;
   localparam seg_t SEG_GLYPH_C = 7'b1000110;
   localparam seg_t SEG_GLYPH_D = 7'b0100001;
   localparam seg_t SEG_GLYPH_E = 7'b0000110;
   localparam seg_t SEG_GLYPH_F = 7'b0001110;

   // Capture FSM state encoding, also visible on the state_dbg port.
   typedef logic [1:0] cap_state_t;
   localparam cap_state_t ST_IDLE  = 2'd0;
   localparam cap_state_t ST_TRACK = 2'd1;
   localparam cap_state_t ST_HOLD  = 2'd2;

   localparam int CNT_W = 8;

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational segment-pattern to nibble classifier (inverse of the 7-segment decoder).
// Define SEEN SEVEN_SEG_HEX_EXT_EN to also accept the A-F glyphs as legal numerals.
module seven_seg_encoder
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output logic       legal_o,
   output logic       blank_o
);

   always_comb begin
      nibble_o = 4'h0;
      legal_o  = 1'b1;
      blank_o  = 1'b0;
      case (seg_i)
         SEG_GLYPH_0: nibble_o = 4'h0;
         SEG_GLYPH_1: nibble_o = 4'h1;
         SEG_GLYPH_2: nibble_o = 4'h2;
         SEG_GLYPH_3: nibble_o = 4'h3;
         SEG_GLYPH_4: nibble_o = 4'h4;
         SEG_GLYPH_5: nibble_o = 4'h5;
         SEG_GLYPH_6: nibble_o = 4'h6;
         SEG_GLYPH_7: nibble_o = 4'h7;
         SEG_GLYPH_8: nibble_o = 4'h8;
         SEG_GLYPH_9: nibble_o = 4'h9;
`ifdef SEVEN_SEG_HEX_EXT_EN
         SEG_GLYPH_A: nibble_o = 4'hA;
         SEG_GLYPH_B: nibble_o = 4'hB;
         SEG_GLYPH_C: nibble_o = 4'hC;
         SEG_GLYPH_D: nibble_o = 4'hD;
         SEG_GLYPH_E: nibble_o = 4'hE;
         SEG_GLYPH_F: nibble_o = 4'hF;
`endif
         SEG_BLANK: begin
            legal_o = 1'b0;
            blank_o = 1'b1;
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers per-digit values from a multiplexed active-low 7-segment bus with a stability filter.
// Build option: SEVEN_SEG_HEX_EXT_EN (passed to seven_seg_encoder) accepts hex glyphs A-F.
module seven_seg_capture
   import seven_seg_pkg::*;
#(
   parameter int  NUM_DIGITS    = 2,
   parameter int  STABLE_CYCLES = 4,
   localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] digit_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   pattern_err,
   output logic                    upd_strobe,
   output logic [IDX_W-1:0]        upd_idx,
   output logic [1:0]              state_dbg
);

   seg_t                    seg_s1_q, seg_s2_q, seg_prev_q;
   logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;

   cap_state_t              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    capture;
   logic                    single;
   logic                    changed;
   logic [IDX_W-1:0]        cap_idx;

   logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   err_q, err_d;
   logic                    strobe_q, strobe_d;
   logic [IDX_W-1:0]        idx_q, idx_d;

   logic [3:0]              enc_nibble;
   logic                    enc_legal;
   logic                    enc_blank;

   // Synchronizers and previous-sample register idle high, i.e. no anode driven.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_s1_q   <= SEG_BLANK;
         seg_s2_q   <= SEG_BLANK;
         seg_prev_q <= SEG_BLANK;
         an_s1_q    <= '1;
         an_s2_q    <= '1;
         an_prev_q  <= '1;
      end else begin
         seg_s1_q   <= seg_in;
         seg_s2_q   <= seg_s1_q;
         seg_prev_q <= seg_s2_q;
         an_s1_q    <= an_in;
         an_s2_q    <= an_s1_q;
         an_prev_q  <= an_s2_q;
      end
   end

   seven_seg_encoder u_encoder (
      .seg_i    (seg_s2_q),
      .nibble_o (enc_nibble),
      .legal_o  (enc_legal),
      .blank_o  (enc_blank)
   );

   assign single  = $onehot(~an_s2_q);
   assign changed = ({an_s2_q, seg_s2_q} != {an_prev_q, seg_prev_q});

   always_comb begin
      cap_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_s2_q[i]) cap_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (single) begin
               state_d = ST_TRACK;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_TRACK: begin
            if (changed) begin
               state_d = single ? ST_TRACK : ST_IDLE;
               cnt_d   = single ? CNT_W'(1) : '0;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (changed) begin
               state_d = single ? ST_TRACK : ST_IDLE;
               cnt_d   = single ? CNT_W'(1) : '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Illegal patterns keep the previous nibble so the last good value stays readable.
   always_comb begin
      digit_d  = digit_q;
      valid_d  = valid_q;
      err_d    = err_q;
      idx_d    = idx_q;
      strobe_d = 1'b0;
      if (capture) begin
         strobe_d = 1'b1;
         idx_d    = cap_idx;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2_q[i]) begin
               if (enc_legal) begin
                  digit_d[4*i +: 4] = enc_nibble;
                  valid_d[i]        = 1'b1;
                  err_d[i]          = 1'b0;
               end else if (enc_blank) begin
                  digit_d[4*i +: 4] = 4'h0;
                  valid_d[i]        = 1'b0;
                  err_d[i]          = 1'b0;
               end else begin
                  valid_d[i]        = 1'b0;
                  err_d[i]          = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         digit_q  <= '0;
         valid_q  <= '0;
         err_q    <= '0;
         strobe_q <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         digit_q  <= digit_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         strobe_q <= strobe_d;
         idx_q    <= idx_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = valid_q;
   assign pattern_err = err_q;
   assign upd_strobe  = strobe_q;
   assign upd_idx     = idx_q;
   assign state_dbg   = state_q;

endmodule
